// File: rtl/mct_pkg.sv
// Shared constants and types for the MCT result path: result width, cache-line
// geometry and the packed result-line type.
package mct_pkg;

    localparam int RESULT_W   = 16;
    localparam int LINE_W     = 512;
    localparam int SLOTS      = LINE_W / RESULT_W;
    localparam int SLOT_IDX_W = $clog2(SLOTS);

    localparam logic [RESULT_W-1:0] PAD_RESULT = 16'h0000;

    // Slot 0 sits at the LSB end of the line.
    typedef logic [SLOTS-1:0][RESULT_W-1:0] result_line_t;

endpackage

// File: rtl/mct_result_packer.sv
// Packs per-query engine results into cache lines for the AXI write master,
// pads the final partial line of a batch and counts emitted lines.
module mct_result_packer
    import mct_pkg::*;
#(
    parameter int                      DATA_WIDTH   = LINE_W,
    parameter int                      RESULT_WIDTH = RESULT_W,
    parameter logic [RESULT_WIDTH-1:0] PAD_VALUE    = PAD_RESULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start,
    input  logic [RESULT_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [31:0]             lines_out,
    output logic                    batch_done
);

    localparam int NSLOT = DATA_WIDTH / RESULT_WIDTH;
    localparam int IDX_W = $clog2(NSLOT);

    typedef logic [NSLOT-1:0][RESULT_WIDTH-1:0] line_t;

    function automatic line_t pad_line();
        line_t l;
        for (int k = 0; k < NSLOT; k++) begin
            l[k] = PAD_VALUE;
        end
        return l;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    line_t            buf_q, buf_d, line_d, data_q;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic             vld_q, last_q;
    logic [31:0]      lines_q;
    logic             in_hs, out_hs, complete;

    assign in_ready = !vld_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = vld_q && out_ready;
    assign complete = in_hs && ((slot_q == IDX_W'(NSLOT - 1)) || in_last);

    always_comb begin
        line_d = buf_q;
        for (int k = 0; k < NSLOT; k++) begin
            if (k == int'(slot_q)) begin
                line_d[k] = in_data;
            end else if (k > int'(slot_q)) begin
                line_d[k] = PAD_VALUE;
            end
        end

        buf_d  = buf_q;
        slot_d = slot_q;
        if (complete) begin
            buf_d  = pad_line();
            slot_d = '0;
        end else if (in_hs) begin
            buf_d[slot_q] = in_data;
            slot_d        = slot_q + IDX_W'(1);
        end
    end

    // A completion may coincide with the handshake of the previous line; the
    // reload then keeps out_valid high so lines stream without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            buf_q   <= pad_line();
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            lines_q <= '0;
        end else if (ctrl_start) begin
            slot_q  <= '0;
            buf_q   <= pad_line();
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            lines_q <= '0;
        end else begin
            slot_q <= slot_d;
            buf_q  <= buf_d;
            if (complete) begin
                data_q <= line_d;
                vld_q  <= 1'b1;
                last_q <= in_last;
            end else if (out_hs) begin
                vld_q <= 1'b0;
            end
            if (out_hs) begin
                lines_q <= sat_inc(lines_q);
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = vld_q;
    assign out_last   = last_q;
    assign lines_out  = lines_q;
    assign batch_done = out_hs && last_q && !ctrl_start;

endmodule

// File: tb/tb_mct_result_packer.sv
// Directed bench for mct_result_packer: full, partial and padded lines,
// back-pressure, mid-batch restart and asynchronous reset.
module tb_mct_result_packer;
    import mct_pkg::*;

    logic         clk = 1'b0;
    logic         rst, ctrl_start, in_valid, in_last, in_ready;
    logic         out_valid, out_ready, out_last, batch_done;
    logic [15:0]  in_data;
    logic [511:0] out_data;
    logic [31:0]  lines_out;

    always #5 clk = ~clk;

    mct_result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_start (ctrl_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .lines_out  (lines_out),
        .batch_done (batch_done)
    );

    int           n_chk = 0;
    int           n_pass = 0;
    logic [511:0] got_q[$];
    logic         got_last_q[$];
    int           n_done;
    logic         prev_stall;
    logic [511:0] prev_data;
    logic         prev_last;
    logic         last_in_hs;
    result_line_t exp_line;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive at the falling edge, sample 1 ns later; handshakes seen here
    // commit at the following rising edge.
    task automatic step(input logic cs, input logic iv, input logic [15:0] d,
                        input logic il, input logic ordy);
        @(negedge clk);
        ctrl_start = cs;
        in_valid   = iv;
        in_data    = d;
        in_last    = il;
        out_ready  = ordy;
        #1;
        if (prev_stall && out_valid && !cs) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_last", 512'(out_last), 512'(prev_last));
        end
        last_in_hs = iv && in_ready && !cs;
        if (out_valid && out_ready && !cs) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
            if (batch_done) n_done++;
        end
        prev_stall = out_valid && !out_ready && !cs;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic send(input logic [15:0] d, input logic il, input bit rnd);
        int budget;
        budget = 0;
        do begin
            step(1'b0, 1'b1, d, il, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            budget++;
        end while (!last_in_hs && budget < 100);
        if (!last_in_hs) chk("send_timeout", 512'(last_in_hs), 512'(1));
    endtask

    task automatic drain(input int n, input bit rnd);
        int budget;
        budget = 0;
        while (got_q.size() < n && budget < 200) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            budget++;
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("line_count", 512'(got_q.size()), 512'(n));
    endtask

    task automatic clear_sb();
        got_q.delete();
        got_last_q.delete();
        n_done     = 0;
        prev_stall = 1'b0;
    endtask

    task automatic start_batch();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        clear_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ctrl_start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        clear_sb();
        #12;
        chk("rst_in_ready",   512'(in_ready),   512'(1));
        chk("rst_out_valid",  512'(out_valid),  512'(0));
        chk("rst_out_last",   512'(out_last),   512'(0));
        chk("rst_out_data",   out_data,         512'(0));
        chk("rst_lines_out",  512'(lines_out),  512'(0));
        chk("rst_batch_done", 512'(batch_done), 512'(0));
        @(negedge clk);
        rst = 1'b0;

        // 32 results fill exactly one line that is also the last
        start_batch();
        for (int i = 0; i < 32; i++) send(16'(i), i == 31, 1'b0);
        drain(1, 1'b0);
        for (int k = 0; k < 32; k++) exp_line[k] = 16'(k);
        if (got_q.size() >= 1) begin
            chk("full_data", got_q[0], exp_line);
            chk("full_last", 512'(got_last_q[0]), 512'(1));
        end
        chk("full_done",  512'(n_done),    512'(1));
        chk("full_lines", 512'(lines_out), 512'(1));

        // 5 results, padded remainder, one-cycle latency
        start_batch();
        for (int i = 0; i < 5; i++) begin
            send(16'hA001 + 16'(i), i == 4, 1'b0);
            if (i == 4) chk("lat_before", 512'(out_valid), 512'(0));
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("lat_after", 512'(out_valid), 512'(1));
        drain(1, 1'b0);
        for (int k = 0; k < 32; k++) exp_line[k] = (k < 5) ? 16'hA001 + 16'(k) : 16'h0000;
        if (got_q.size() >= 1) begin
            chk("part_data", got_q[0], exp_line);
            chk("part_last", 512'(got_last_q[0]), 512'(1));
        end
        chk("part_lines", 512'(lines_out), 512'(1));

        // 100 results under random back-pressure
        start_batch();
        for (int i = 0; i < 100; i++) send(16'h3000 + 16'(i), i == 99, 1'b1);
        drain(4, 1'b1);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 32; k++)
                exp_line[k] = (j * 32 + k < 100) ? 16'h3000 + 16'(j * 32 + k) : 16'h0000;
            if (got_q.size() > j) begin
                chk($sformatf("bp_data%0d", j), got_q[j], exp_line);
                chk($sformatf("bp_last%0d", j), 512'(got_last_q[j]), 512'(j == 3));
            end
        end
        chk("bp_lines", 512'(lines_out), 512'(4));
        chk("bp_done",  512'(n_done),    512'(1));

        // completion in the same cycle as the previous line's handshake
        start_batch();
        send(16'hC001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovl_stall_ready", 512'(in_ready), 512'(0));
        step(1'b0, 1'b1, 16'hC002, 1'b1, 1'b1);
        chk("ovl_in_ready", 512'(in_ready), 512'(1));
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovl_valid", 512'(out_valid), 512'(1));
        for (int k = 0; k < 32; k++) exp_line[k] = (k == 0) ? 16'hC002 : 16'h0000;
        chk("ovl_new_data", out_data, exp_line);
        drain(2, 1'b0);
        for (int k = 0; k < 32; k++) exp_line[k] = (k == 0) ? 16'hC001 : 16'h0000;
        if (got_q.size() >= 1) chk("ovl_first_data", got_q[0], exp_line);
        chk("ovl_lines", 512'(lines_out), 512'(2));

        // restart mid-batch discards the partial line
        start_batch();
        for (int i = 0; i < 10; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0);
        start_batch();
        for (int i = 0; i < 3; i++) send(16'h5100 + 16'(i), i == 2, 1'b0);
        drain(1, 1'b0);
        for (int k = 0; k < 32; k++) exp_line[k] = (k < 3) ? 16'h5100 + 16'(k) : 16'h0000;
        if (got_q.size() >= 1) chk("restart_data", got_q[0], exp_line);
        chk("restart_lines", 512'(lines_out), 512'(1));

        // asynchronous reset while a line is stalled
        start_batch();
        send(16'hD001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("arst_pre_valid", 512'(out_valid), 512'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid",  512'(out_valid),  512'(0));
        chk("arst_out_last",   512'(out_last),   512'(0));
        chk("arst_out_data",   out_data,         512'(0));
        chk("arst_lines_out",  512'(lines_out),  512'(0));
        chk("arst_in_ready",   512'(in_ready),   512'(1));
        chk("arst_batch_done", 512'(batch_done), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        send(16'hB001, 1'b0, 1'b0);
        send(16'hB002, 1'b1, 1'b0);
        drain(1, 1'b0);
        for (int k = 0; k < 32; k++)
            exp_line[k] = (k == 0) ? 16'hB001 : (k == 1) ? 16'hB002 : 16'h0000;
        if (got_q.size() >= 1) chk("arst_next_data", got_q[0], exp_line);
        chk("arst_next_lines", 512'(lines_out), 512'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mct_result_packer.md
# mct_result_packer

Packs the per-query 16-bit results produced by the MCT engine core into 512-bit result cache lines for the AXI4 write master. Sits between `mct_wrapper`'s result output and the write master's `s_axis` input. Counts emitted lines so the kernel can check them against the host-programmed result size. Pads the final partial line so every query batch ends on a full cache line.

## Interface
- `DATA_WIDTH`, 512, output line width in bits.
- `RESULT_WIDTH`, 16, width of one engine result.
- `PAD_VALUE`, 16'h0000, fill value for unused slots of the final line.

Ports:
- `clk`  in  1  kernel clock, single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `ctrl_start`  in  1  single-cycle pulse that starts a batch and clears all state.
- `in_data`  in  RESULT_WIDTH  engine result.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  the current result is the last one of the batch.
- `in_ready`  out  1  the packer accepts the result this cycle.
- `out_data`  out  DATA_WIDTH  packed result line.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the write master accepts the line.
- `out_last`  out  1  this line holds the batch's last result.
- `lines_out`  out  32  lines handshaken on the output since the last `ctrl_start`.
- `batch_done`  out  1  one-cycle pulse when the `out_last` line is handshaken.

## Operation
- SLOTS = DATA_WIDTH/RESULT_WIDTH, which is 32 by default. Slot k occupies bits [RESULT_WIDTH*k +: RESULT_WIDTH], so slot 0 is the LSB end.
- State: assembly buffer, 5-bit slot counter, output register (`out_data`, `out_valid`, `out_last`), 32-bit line counter.
- `in_ready` = !`out_valid` || `out_ready`.
- Input handshake: `in_valid` && `in_ready`. On each input handshake, the result is written into the slot counter's slot, and the slot counter increments.
- Line completion is an input handshake with slot == SLOTS-1, or with `in_last`=1. On completion:
  - the output register loads the assembled line, including the current result;
  - on `in_last`, slots above the current slot are filled with PAD_VALUE;
  - `out_valid` is set, `out_last` is set to `in_last`, the slot counter returns to 0 and the buffer is refilled with PAD_VALUE.
- An output handshake (`out_valid` && `out_ready`) with no simultaneous completion clears `out_valid`.
- On an output handshake, `lines_out` increments. It saturates at 2^32-1.
- `batch_done` = output handshake && `out_last`.
- `ctrl_start` synchronously clears the slot counter, the buffer (to PAD), `out_valid`, `out_last` and `lines_out`. It wins over any simultaneous handshake; a partial line or pending output line is discarded.
- `in_last` on slot SLOTS-1 produces a single full line with `out_last`=1 and no extra pad line.
- A batch with no results produces no lines.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `lines_out`=0, `batch_done`=0. Reset asserted mid-batch discards all data immediately.
- Latency: `out_valid` rises 1 cycle after the completing input handshake.
- Throughput: one result per cycle. A full line is produced every SLOTS cycles with no bubble when `out_ready` is held high.
- Completion while the previous line is being handshaken: the output register reloads in the same cycle and `out_valid` stays 1.
- `out_ready` low with `out_valid` high: `in_ready`=0 and `out_data`/`out_last` are held stable (AXI-Stream rule).
- `out_valid` never depends combinationally on `out_ready`.
- `in_ready` depends combinationally on `out_ready` only. This is a single gate level; the write master's input FIFO registers `tready`.

## Structure
- Shared package `mct_pkg`: RESULT_WIDTH, DATA_WIDTH, SLOTS, slot-index width, PAD_VALUE, and the result-line packed typedef (an array of SLOTS result fields).
- Single flat module; no sub-module. The slot counter, assembly buffer and output register are too small to split.

## Test plan
- 32 results 0x0000..0x001F, `out_ready`=1 throughout, `in_last` on the 32nd:
  - one line with slot k = k, `out_last`=1, `batch_done` pulse;
  - `lines_out`=1.
- 5 results 0xA001..0xA005, `in_last` on the 5th:
  - one line with slots 0-4 = A001..A005 and slots 5-31 = 0x0000, `out_last`=1;
  - `out_valid` one cycle after the 5th handshake.
- 100 back-to-back results with random `out_ready` (50%):
  - 4 lines, the last with slots 4-31 padded;
  - no lost or duplicated result, and `out_data` stable while stalled;
  - `lines_out`=4.
- Completion cycle coinciding with an output handshake: `out_valid` stays 1, the new line appears on the next cycle, and `in_ready` stays 1.
- `ctrl_start` after 10 results of a batch, then 3 results with `in_last`: only one line (slots 0-2) is emitted, and `lines_out`=1.
- `rst` asserted while `out_valid`=1 and `out_ready`=0: all outputs reach their reset values asynchronously, and the next batch packs from slot 0.
